// File: rtl/pixel_plot_sink.sv
// -----------------------------------------------------------------------------
// pixel_plot_sink
//
// Receiving end of the renderer pixel plot stream. Accepted pixels are clipped
// to the 160x120 screen, converted to a linear framebuffer address
// (y*160 + x) and queued in a small FIFO. The FIFO head is offered to the
// framebuffer memory port through a valid/ready handshake, so renderers can
// plot one pixel per cycle while the memory port back-pressures.
//
// Optional feature (macro PLOT_SINK_CLEAR_EN): a full-screen clear engine
// that writes clear_colour to addresses 0..19199 once the FIFO has drained.
//
// Parameters:
//   DEPTH        FIFO entries (power of two, >= 2)
//   AW           log2(DEPTH), FIFO pointer width
//
// Ports:
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   x, y         pixel column / row
//   colour       pixel colour
//   plot         write strobe for x/y/colour
//   mem_addr     framebuffer address of the current write
//   mem_data     colour of the current write
//   mem_we       write request (valid)
//   mem_ready    memory accepts the write when mem_we is also high
//   fifo_level   number of queued pixels
//   overflow     sticky: an in-bounds pixel was dropped on a full FIFO
//   clr_ovf      synchronous clear of overflow (a same-edge set wins)
//   clear_req    (PLOT_SINK_CLEAR_EN) request a full-screen clear
//   clear_colour (PLOT_SINK_CLEAR_EN) colour used by the clear
//   clear_done   (PLOT_SINK_CLEAR_EN) one-cycle pulse after the last clear write
//   busy         FIFO non-empty or clear pending/in progress
// -----------------------------------------------------------------------------
module pixel_plot_sink #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [7:0]    x,
    input  logic [6:0]    y,
    input  logic [2:0]    colour,
    input  logic          plot,
    output logic [14:0]   mem_addr,
    output logic [2:0]    mem_data,
    output logic          mem_we,
    input  logic          mem_ready,
    output logic [AW:0]   fifo_level,
    output logic          overflow,
    input  logic          clr_ovf,
`ifdef PLOT_SINK_CLEAR_EN
    input  logic          clear_req,
    input  logic [2:0]    clear_colour,
    output logic          clear_done,
`endif
    output logic          busy
);

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [14:0] LAST_ADDR  = 15'd19199;

`ifdef PLOT_SINK_CLEAR_EN
    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CLEAR} state_t;
`else
    typedef enum logic {ST_IDLE, ST_DRAIN} state_t;
`endif

    typedef struct packed {
        logic [14:0] addr;
        logic [2:0]  colour;
    } entry_t;

    entry_t          fifo_mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic            overflow_q, overflow_d;
    state_t          state_q, state_d;

    logic            in_bounds;
    logic            fifo_empty;
    logic            fifo_full;
    logic            fifo_push;
    logic            fifo_pop;
    logic            ovf_set;
    logic            clearing;
    logic [14:0]     pix_addr;
    logic [14:0]     y_ext;
    entry_t          head;

`ifdef PLOT_SINK_CLEAR_EN
    logic [14:0]     clr_addr_q, clr_addr_d;
    logic [2:0]      clr_colour_q, clr_colour_d;
    logic            clr_pend_q, clr_pend_d;
    logic            clear_done_q, clear_done_d;
    logic            drained;
`endif

    // -------------------------------------------------------------------------
    // Clipping, address generation and FIFO control
    // -------------------------------------------------------------------------
    always_comb begin
        in_bounds  = (x < 8'd160) && (y < 7'd120);
        // y*160 = y*128 + y*32; maximum result 19199 fits in 15 bits.
        y_ext      = {8'd0, y};
        pix_addr   = (y_ext << 7) + (y_ext << 5) + {7'd0, x};

        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == FULL_LEVEL);
`ifdef PLOT_SINK_CLEAR_EN
        clearing   = (state_q == ST_CLEAR);
`else
        clearing   = 1'b0;
`endif
        // The FIFO head is not offered to memory while the clear engine owns the port.
        fifo_pop   = !fifo_empty && mem_ready && !clearing;
        fifo_push  = plot && in_bounds && (!fifo_full || fifo_pop);
        ovf_set    = plot && in_bounds && fifo_full && !fifo_pop;

        wr_ptr_d   = fifo_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = fifo_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d    = level_q;
        case ({fifo_push, fifo_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // Set has priority over a coincident clear.
        overflow_d = overflow_q;
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
`ifdef PLOT_SINK_CLEAR_EN
        clr_addr_d   = clr_addr_q;
        clr_colour_d = clr_colour_q;
        clr_pend_d   = clr_pend_q;
        clear_done_d = 1'b0;
        drained      = fifo_empty || ((level_q == (AW + 1)'(1)) && fifo_pop);
`endif

        case (state_q)
            ST_IDLE: begin
                if (fifo_push) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (level_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef PLOT_SINK_CLEAR_EN
            ST_CLEAR: begin
                if (mem_ready) begin
                    if (clr_addr_q == LAST_ADDR) begin
                        clear_done_d = 1'b1;
                        state_d      = (level_d != '0) ? ST_DRAIN : ST_IDLE;
                    end else begin
                        clr_addr_d = clr_addr_q + 15'd1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

`ifdef PLOT_SINK_CLEAR_EN
        // A request waits for the queued pixels to drain; pixels pushed on the
        // entry edge stay queued until the clear finishes.
        if (state_q != ST_CLEAR) begin
            if (clear_req) begin
                clr_colour_d = clear_colour;
            end
            if ((clear_req || clr_pend_q) && drained) begin
                state_d    = ST_CLEAR;
                clr_pend_d = 1'b0;
                clr_addr_d = '0;
            end else if (clear_req) begin
                clr_pend_d = 1'b1;
            end
        end
`endif
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values computed in always_comb.
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
        end
    end

`ifdef PLOT_SINK_CLEAR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clr_addr_q   <= '0;
            clr_colour_q <= '0;
            clr_pend_q   <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            clr_addr_q   <= clr_addr_d;
            clr_colour_q <= clr_colour_d;
            clr_pend_q   <= clr_pend_d;
            clear_done_q <= clear_done_d;
        end
    end
`endif

    // NOTE: the storage array has no reset; an entry is only read after it has
    // been written, and the empty case is masked to zero on the outputs.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem_q[wr_ptr_q] <= '{addr: pix_addr, colour: colour};
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, all derived from registered state
    // -------------------------------------------------------------------------
    always_comb begin
        head     = fifo_mem_q[rd_ptr_q];
        mem_we   = !fifo_empty;
        mem_addr = fifo_empty ? 15'd0 : head.addr;
        mem_data = fifo_empty ? 3'd0  : head.colour;
        busy     = !fifo_empty;
`ifdef PLOT_SINK_CLEAR_EN
        if (clearing) begin
            mem_we   = 1'b1;
            mem_addr = clr_addr_q;
            mem_data = clr_colour_q;
        end
        busy       = !fifo_empty || clearing || clr_pend_q;
        clear_done = clear_done_q;
`endif
        fifo_level = level_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_pixel_plot_sink.sv
// -----------------------------------------------------------------------------
// tb_pixel_plot_sink
//
// Directed self-checking bench for pixel_plot_sink with DEPTH=4. Inputs are
// driven and outputs sampled 1 ns after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_pixel_plot_sink;

    logic        clk;
    logic        resetn;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_ready;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        clr_ovf;
    logic        busy;
`ifdef PLOT_SINK_CLEAR_EN
    logic        clear_req;
    logic [2:0]  clear_colour;
    logic        clear_done;
`endif

    int compared   = 0;
    int mismatched = 0;

    pixel_plot_sink #(.DEPTH(4), .AW(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_we       (mem_we),
        .mem_ready    (mem_ready),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .clr_ovf      (clr_ovf),
`ifdef PLOT_SINK_CLEAR_EN
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .clear_done   (clear_done),
`endif
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pixel(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
        plot   = 1'b1;
        x      = px;
        y      = py;
        colour = pc;
    endtask

    initial begin
        resetn    = 1'b0;
        x         = '0;
        y         = '0;
        colour    = '0;
        plot      = 1'b0;
        mem_ready = 1'b0;
        clr_ovf   = 1'b0;
`ifdef PLOT_SINK_CLEAR_EN
        clear_req    = 1'b0;
        clear_colour = '0;
`endif

        // Reset state
        tick();
        check("rst_mem_we",   32'(mem_we),     0);
        check("rst_level",    32'(fifo_level), 0);
        check("rst_overflow", 32'(overflow),   0);
        check("rst_busy",     32'(busy),       0);
        check("rst_addr",     32'(mem_addr),   0);
        check("rst_data",     32'(mem_data),   0);
        resetn = 1'b1;
        tick();

        // Single pixel: (3,4) -> 4*160+3 = 643
        mem_ready = 1'b1;
        drive_pixel(8'd3, 7'd4, 3'd5);
        tick();
        plot = 1'b0;
        check("single_we",    32'(mem_we),     1);
        check("single_addr",  32'(mem_addr),   643);
        check("single_data",  32'(mem_data),   5);
        check("single_level", 32'(fifo_level), 1);
        check("single_busy",  32'(busy),       1);
        tick();
        check("single_drain_level", 32'(fifo_level), 0);
        check("single_drain_we",    32'(mem_we),     0);
        check("single_drain_busy",  32'(busy),       0);

        // Corner pixel (159,119) -> 19199
        drive_pixel(8'd159, 7'd119, 3'd2);
        tick();
        plot = 1'b0;
        check("corner_addr", 32'(mem_addr), 19199);
        check("corner_data", 32'(mem_data), 2);
        tick();
        check("corner_drain_level", 32'(fifo_level), 0);

        // Out-of-bounds plots are discarded silently
        drive_pixel(8'd160, 7'd0, 3'd1);
        tick();
        check("clip_x_level", 32'(fifo_level), 0);
        check("clip_x_we",    32'(mem_we),     0);
        drive_pixel(8'd0, 7'd120, 3'd1);
        tick();
        plot = 1'b0;
        check("clip_y_level", 32'(fifo_level), 0);
        check("clip_y_ovf",   32'(overflow),   0);

        // Back-pressure: five pixels (i,1) -> addr 160+i, colour i+1
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_pixel(8'(i), 7'd1, 3'(i + 1));
            tick();
            if (i == 3) begin
                check("bp_full_level", 32'(fifo_level), 4);
                check("bp_full_ovf",   32'(overflow),   0);
            end
        end
        plot = 1'b0;
        check("bp_level", 32'(fifo_level), 4);
        check("bp_ovf",   32'(overflow),   1);
        check("bp_addr",  32'(mem_addr),   160);
        check("bp_data",  32'(mem_data),   1);
        tick();
        check("bp_hold_addr", 32'(mem_addr), 160);
        check("bp_hold_data", 32'(mem_data), 1);
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_order_we",   32'(mem_we),   1);
            check("bp_order_addr", 32'(mem_addr), 32'(160 + i));
            check("bp_order_data", 32'(mem_data), 32'(i + 1));
            tick();
        end
        check("bp_empty_we",    32'(mem_we),     0);
        check("bp_empty_level", 32'(fifo_level), 0);
        check("bp_ovf_sticky",  32'(overflow),   1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_ovf", 32'(overflow), 0);

        // Full with a pop on every edge: (10+i,2) -> 330+i, then (20+i,2) -> 340+i
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_pixel(8'(10 + i), 7'd2, 3'd3);
            tick();
        end
        check("fp_level", 32'(fifo_level), 4);
        check("fp_addr",  32'(mem_addr),   330);
        mem_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            drive_pixel(8'(20 + k - 1), 7'd2, 3'd4);
            tick();
            check("fp_level_held", 32'(fifo_level), 4);
            check("fp_no_ovf",     32'(overflow),   0);
            check("fp_head_addr",  32'(mem_addr),   (k < 4) ? 32'(330 + k) : 32'(340 + k - 4));
        end
        plot      = 1'b0;
        mem_ready = 1'b0;

        // Overflow set and clear on the same edge: set wins
        drive_pixel(8'd50, 7'd50, 3'd7);
        clr_ovf = 1'b1;
        tick();
        plot    = 1'b0;
        clr_ovf = 1'b0;
        check("ovf_set_wins", 32'(overflow), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);

        // Reset mid-drain with three entries queued
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("mid_level", 32'(fifo_level), 3);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_we",    32'(mem_we),     0);
        check("async_rst_level", 32'(fifo_level), 0);
        check("async_rst_busy",  32'(busy),       0);
        tick();
        resetn    = 1'b1;
        mem_ready = 1'b1;
        tick();
        tick();
        check("post_rst_we",    32'(mem_we),     0);
        check("post_rst_level", 32'(fifo_level), 0);

`ifdef PLOT_SINK_CLEAR_EN
        // Full-screen clear with colour 1; a pixel plotted mid-clear follows it
        begin
            int bad_writes;
            int done_early;
            bad_writes   = 0;
            done_early   = 0;
            clear_colour = 3'd1;
            clear_req    = 1'b1;
            tick();
            clear_req = 1'b0;
            check("clr_busy", 32'(busy), 1);
            for (int n = 0; n < 19200; n++) begin
                if (n == 100) begin
                    drive_pixel(8'd5, 7'd0, 3'd6);
                end else begin
                    plot = 1'b0;
                end
                if (!(mem_we === 1'b1 && mem_addr === 15'(n) && mem_data === 3'd1)) begin
                    bad_writes++;
                end
                if (clear_done !== 1'b0) begin
                    done_early++;
                end
                tick();
            end
            plot = 1'b0;
            check("clr_bad_writes", 32'(bad_writes), 0);
            check("clr_done_early", 32'(done_early), 0);
            check("clr_done_pulse", 32'(clear_done), 1);
            check("clr_pixel_addr", 32'(mem_addr),   5);
            check("clr_pixel_data", 32'(mem_data),   6);
            tick();
            check("clr_done_low",    32'(clear_done), 0);
            check("clr_after_level", 32'(fifo_level), 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
